// File: rtl/stream_distributor_pkg.sv
// Shared types and constants for the stream distributor.
package stream_distributor_pkg;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_CNT_WIDTH = 16;

    // Output channel indices; sel is a single bit choosing between them.
    localparam logic SEL_Z = 1'b0;
    localparam logic SEL_Y = 1'b1;

    typedef enum logic {
        RECV = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage : stream_distributor_pkg

// File: rtl/stream_distributor.sv
// stream_distributor: splits one stb/ack stream onto two stb/ack outputs.
// Default build routes words round-robin (output_z first, then output_y).
// With STREAM_DISTRIBUTOR_ROUTE_BY_MSB_EN defined, each word is routed by its
// MSB instead: 0 -> output_z, 1 -> output_y. Per-output wrapping counters
// record delivered words for debug.
module stream_distributor
    import stream_distributor_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     input_a,
    input  logic                 input_a_stb,
    output logic                 input_a_ack,
    output logic [WIDTH-1:0]     output_z,
    output logic                 output_z_stb,
    input  logic                 output_z_ack,
    output logic [WIDTH-1:0]     output_y,
    output logic                 output_y_stb,
    input  logic                 output_y_ack,
    output logic [CNT_WIDTH-1:0] count_z,
    output logic [CNT_WIDTH-1:0] count_y
);

    state_e               state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 in_ack_q, in_ack_d;
    logic [1:0]           stb_q, stb_d;
    logic [WIDTH-1:0]     data_q [2];
    logic [WIDTH-1:0]     data_d [2];
    logic [CNT_WIDTH-1:0] cnt_q [2];
    logic [CNT_WIDTH-1:0] cnt_d [2];

    logic [1:0]           out_ack;
    logic                 route;
    logic                 sel_after_send;

    assign out_ack[SEL_Z] = output_z_ack;
    assign out_ack[SEL_Y] = output_y_ack;

    // Output picked for the word being captured, and sel after a delivery.
    always_comb begin
`ifdef STREAM_DISTRIBUTOR_ROUTE_BY_MSB_EN
        route          = input_a[WIDTH-1];
        sel_after_send = sel_q;
`else
        route          = sel_q;
        sel_after_send = ~sel_q;
`endif
    end

    // Next-state and datapath update for the RECV/SEND handshake sequencer.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        in_ack_d = in_ack_q;
        stb_d    = stb_q;
        data_d   = data_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            RECV: begin
                in_ack_d = 1'b1;
                if (in_ack_q && input_a_stb) begin
                    data_d[route] = input_a;
                    stb_d[route]  = 1'b1;
                    sel_d         = route;
                    in_ack_d      = 1'b0;
                    state_d       = SEND;
                end
            end
            SEND: begin
                // Only the selected channel's ack can complete the transfer.
                if (stb_q[sel_q] && out_ack[sel_q]) begin
                    stb_d[sel_q] = 1'b0;
                    cnt_d[sel_q] = cnt_q[sel_q] + CNT_WIDTH'(1);
                    sel_d        = sel_after_send;
                    in_ack_d     = 1'b1;
                    state_d      = RECV;
                end
            end
            default: begin
                state_d = RECV;
            end
        endcase
    end

    // State and datapath registers; synchronous reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RECV;
            sel_q     <= SEL_Z;
            in_ack_q  <= 1'b0;
            stb_q     <= 2'b00;
            data_q[0] <= '0;
            data_q[1] <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            in_ack_q  <= in_ack_d;
            stb_q     <= stb_d;
            data_q[0] <= data_d[0];
            data_q[1] <= data_d[1];
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
        end
    end

    assign input_a_ack  = in_ack_q;
    assign output_z     = data_q[SEL_Z];
    assign output_z_stb = stb_q[SEL_Z];
    assign output_y     = data_q[SEL_Y];
    assign output_y_stb = stb_q[SEL_Y];
    assign count_z      = cnt_q[SEL_Z];
    assign count_y      = cnt_q[SEL_Y];

endmodule : stream_distributor

// File: tb/tb_stream_distributor.sv
// Directed self-checking bench for stream_distributor.
// Counters are built 4 bits wide here so counter wrap is reachable quickly.
module tb_stream_distributor;

    localparam int unsigned W   = 16;
    localparam int unsigned CW  = 4;

    logic          clk;
    logic          rst;
    logic [W-1:0]  input_a;
    logic          input_a_stb;
    logic          input_a_ack;
    logic [W-1:0]  output_z;
    logic          output_z_stb;
    logic          output_z_ack;
    logic [W-1:0]  output_y;
    logic          output_y_stb;
    logic          output_y_ack;
    logic [CW-1:0] count_z;
    logic [CW-1:0] count_y;

    int n_checks;
    int n_pass;

    // Reference model state
    logic          exp_sel;
    logic          exp_route;
    logic [W-1:0]  exp_data [2];
    logic [CW-1:0] exp_cnt [2];

    stream_distributor #(
        .WIDTH     (W),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack),
        .output_y     (output_y),
        .output_y_stb (output_y_stb),
        .output_y_ack (output_y_ack),
        .count_z      (count_z),
        .count_y      (count_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_stb(input logic s);
        return s ? output_y_stb : output_z_stb;
    endfunction

    function automatic logic [W-1:0] get_data(input logic s);
        return s ? output_y : output_z;
    endfunction

    function automatic logic [CW-1:0] get_cnt(input logic s);
        return s ? count_y : count_z;
    endfunction

    task automatic model_reset();
        exp_sel     = 1'b0;
        exp_route   = 1'b0;
        exp_data[0] = '0;
        exp_data[1] = '0;
        exp_cnt[0]  = '0;
        exp_cnt[1]  = '0;
    endtask

    // Check every observable output against the model.
    task automatic check_all(input string tag, input logic ack_exp, input logic z_stb_exp,
                             input logic y_stb_exp);
        check_eq({tag, ".ack"},   32'(input_a_ack),  32'(ack_exp));
        check_eq({tag, ".zstb"},  32'(output_z_stb), 32'(z_stb_exp));
        check_eq({tag, ".ystb"},  32'(output_y_stb), 32'(y_stb_exp));
        check_eq({tag, ".z"},     32'(output_z),     32'(exp_data[0]));
        check_eq({tag, ".y"},     32'(output_y),     32'(exp_data[1]));
        check_eq({tag, ".cntz"},  32'(count_z),      32'(exp_cnt[0]));
        check_eq({tag, ".cnty"},  32'(count_y),      32'(exp_cnt[1]));
    endtask

    // Offer one word; after the accepting edge the routed stb must be high.
    task automatic send_word(input logic [W-1:0] d);
        for (int n = 0; n < 20 && !input_a_ack; n++) tick();
        check_eq("ack_wait", 32'(input_a_ack), 32'd1);
`ifdef STREAM_DISTRIBUTOR_ROUTE_BY_MSB_EN
        exp_route = d[W-1];
`else
        exp_route = exp_sel;
`endif
        input_a     = d;
        input_a_stb = 1'b1;
        tick();
        input_a_stb = 1'b0;
        exp_data[exp_route] = d;
        exp_sel = exp_route;
        check_all("capture", 1'b0, ~exp_route, exp_route);
    endtask

    // One cycle with the routed consumer ready; word must be delivered.
    task automatic deliver();
        check_eq("pre_deliver_ack", 32'(exp_route ? output_y_ack : output_z_ack), 32'd1);
        tick();
        exp_cnt[exp_route] = exp_cnt[exp_route] + CW'(1);
`ifndef STREAM_DISTRIBUTOR_ROUTE_BY_MSB_EN
        exp_sel = ~exp_sel;
`endif
        check_all("deliver", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        input_a      = '0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b1;
        output_y_ack = 1'b1;
        model_reset();

        // Reset state
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_all("post_reset", 1'b1, 1'b0, 1'b0);

        // Round-robin with both consumers always ready: one word per 2 cycles
        for (int i = 1; i <= 4; i++) begin
            send_word(W'(i));
            deliver();
        end
`ifndef STREAM_DISTRIBUTOR_ROUTE_BY_MSB_EN
        check_eq("rr.z_last", 32'(output_z), 32'h0003);
        check_eq("rr.y_last", 32'(output_y), 32'h0004);
        check_eq("rr.cnt_z",  32'(count_z),  32'd2);
        check_eq("rr.cnt_y",  32'(count_y),  32'd2);
`endif

        // Stalled output_z while output_y_ack stays high: nothing moves
        output_z_ack = 1'b0;
        output_y_ack = 1'b1;
        send_word(16'h1234);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("stall", 1'b0, 1'b1, 1'b0);
        end
        check_eq("stall.data", 32'(get_data(exp_route)), 32'h1234);
        output_z_ack = 1'b1;
        deliver();

        // Next word goes to the other output; hold it in SEND then reset
        output_z_ack = 1'b0;
        output_y_ack = 1'b0;
        send_word(16'h5555);
        tick();
        check_eq("hold.stb", 32'(get_stb(exp_route)), 32'd1);
        check_eq("hold.cnt", 32'(get_cnt(exp_route)), 32'(exp_cnt[exp_route]));
        rst = 1'b1;
        tick();
        model_reset();
        check_all("mid_reset", 1'b0, 1'b0, 1'b0);
        rst          = 1'b0;
        output_z_ack = 1'b1;
        output_y_ack = 1'b1;
        tick();
        check_all("mid_reset_rel", 1'b1, 1'b0, 1'b0);
        send_word(16'hAAAA);
`ifndef STREAM_DISTRIBUTOR_ROUTE_BY_MSB_EN
        check_eq("after_rst.zstb", 32'(output_z_stb), 32'd1);
        check_eq("after_rst.z",    32'(output_z),     32'hAAAA);
`endif
        deliver();

        // Drive counters through their wrap point
        for (int i = 0; i < 30; i++) begin
            send_word(W'(i + 16));
            deliver();
        end
`ifndef STREAM_DISTRIBUTOR_ROUTE_BY_MSB_EN
        check_eq("wrap.pre_z", 32'(count_z), 32'h0);
        check_eq("wrap.pre_y", 32'(count_y), 32'hF);
`endif
        send_word(16'h0077);
        deliver();
`ifndef STREAM_DISTRIBUTOR_ROUTE_BY_MSB_EN
        check_eq("wrap.z", 32'(count_z), 32'h0);
        check_eq("wrap.y", 32'(count_y), 32'h0);
`endif

`ifdef STREAM_DISTRIBUTOR_ROUTE_BY_MSB_EN
        // Content routing by MSB
        send_word(16'h8001);
        check_eq("msb.1.ystb", 32'(output_y_stb), 32'd1);
        check_eq("msb.1.y",    32'(output_y),     32'h8001);
        deliver();
        send_word(16'h8002);
        check_eq("msb.2.ystb", 32'(output_y_stb), 32'd1);
        check_eq("msb.2.y",    32'(output_y),     32'h8002);
        deliver();
        send_word(16'h0003);
        check_eq("msb.3.zstb", 32'(output_z_stb), 32'd1);
        check_eq("msb.3.z",    32'(output_z),     32'h0003);
        deliver();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_stream_distributor
